// File: rtl/execute_unit_if.sv
// rtl/execute_unit_if.sv - fetch, write-back and debug signals of execute_unit
interface execute_unit_if;
  logic [31:0] instruction;
  logic        stall;
  logic        control;
  logic        pc_jump;
  logic [4:0]  jump_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [15:0] retired_count;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    input  instruction, stall, dbg_addr,
    output control, pc_jump, jump_addr, wb_en, wb_addr, wb_data, retired_count, dbg_data
  );

  modport slave (
    output instruction, stall, dbg_addr,
    input  control, pc_jump, jump_addr, wb_en, wb_addr, wb_data, retired_count, dbg_data
  );
endinterface

// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - multi-cycle decode/execute/write-back stage with 32x32 register file
module execute_unit (
  input  logic           clk_i,
  input  logic           rst_ni,
  execute_unit_if.master bus
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_e;

  localparam logic [2:0] OP_J    = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [2:0] OP_SUBI = 3'd7;

  state_e      state_q;
  logic [31:0] regs_q [32];
  logic [2:0]  op_q;
  logic [23:0] fields_q;
  logic [31:0] a_q, b_q;
  logic        jump_pending_q;
  logic [4:0]  jump_target_q;
  logic        wb_we_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic [15:0] retired_q;

  logic [31:0] imm_ext, result_d;
  logic [4:0]  dest_d;
  logic        we_d, taken_d;

  always_comb begin
    imm_ext  = {16'd0, fields_q[15:0]};
    result_d = '0;
    case (op_q)
      OP_ADD:  result_d = a_q + b_q;
      OP_SUB:  result_d = a_q - b_q;
      OP_SHL:  result_d = a_q << b_q[4:0];
      OP_SHR:  result_d = a_q >> b_q[4:0];
      OP_ADDI: result_d = a_q + imm_ext;
      OP_SUBI: result_d = a_q - imm_ext;
      default: result_d = '0;
    endcase
    dest_d  = (op_q == OP_ADDI || op_q == OP_SUBI) ? fields_q[23:19] : fields_q[18:14];
    we_d    = (op_q != OP_J) && (op_q != OP_BEQ) && (dest_d != 5'd0);
    taken_d = (op_q == OP_J) || ((op_q == OP_BEQ) && (a_q == b_q));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= FETCH;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      op_q           <= '0;
      fields_q       <= '0;
      a_q            <= '0;
      b_q            <= '0;
      jump_pending_q <= 1'b0;
      jump_target_q  <= '0;
      wb_we_q        <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      retired_q      <= '0;
    end else if (!bus.stall) begin
      case (state_q)
        // A redirect costs a second FETCH: the word loaded on the redirect edge is stale.
        FETCH: begin
          if (jump_pending_q) jump_pending_q <= 1'b0;
          else                state_q        <= DECODE;
        end
        DECODE: begin
          op_q     <= bus.instruction[31:29];
          fields_q <= bus.instruction[23:0];
          a_q      <= regs_q[bus.instruction[28:24]];
          b_q      <= regs_q[bus.instruction[23:19]];
          state_q  <= EXEC;
        end
        EXEC: begin
          wb_we_q   <= we_d;
          wb_addr_q <= dest_d;
          wb_data_q <= result_d;
          if (taken_d) begin
            jump_pending_q <= 1'b1;
            jump_target_q  <= fields_q[4:0];
          end
          state_q <= WB;
        end
        WB: begin
          if (wb_we_q) regs_q[wb_addr_q] <= wb_data_q;
          retired_q <= retired_q + 16'd1;
          state_q   <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.control       = rst_ni && (state_q == FETCH) && !bus.stall;
  assign bus.pc_jump       = bus.control && jump_pending_q;
  assign bus.jump_addr     = jump_target_q;
  assign bus.wb_en         = rst_ni && (state_q == WB) && wb_we_q && !bus.stall;
  assign bus.wb_addr       = wb_addr_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.retired_count = retired_q;
  assign bus.dbg_data      = (bus.dbg_addr == 5'd0) ? '0 : regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - randomized self-checking bench for execute_unit against an ISA-level model
module tb_execute_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  execute_unit_if bus();
  execute_unit dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int          n_checks, n_errors;
  logic [31:0] mem [32];
  logic [4:0]  pc;
  logic [31:0] ref_regs [32];
  logic [4:0]  ref_pc;
  int          exp_rc;
  logic        exp_pj;
  logic [4:0]  exp_ja;
  logic        prev_wen;
  logic [4:0]  prev_waddr;
  logic [31:0] prev_wdata;
  logic [15:0] prev_rc;
  int          gap;
  logic        have_ctl, last_pj, first_ctl, abort_on_wen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 14'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [2:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, 3'd0, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] tgt);
    return {op, rs, rt, 14'd0, tgt};
  endfunction

  // ISA-level semantics of the next instruction in program order
  task automatic retire_model(input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] ins, a, b, v, imm;
    logic [4:0]  d;
    logic        en, redir;
    ins   = mem[ref_pc];
    a     = ref_regs[ins[28:24]];
    b     = ref_regs[ins[23:19]];
    imm   = {16'd0, ins[15:0]};
    d     = ins[18:14];
    v     = 32'd0;
    en    = 1'b1;
    redir = 1'b0;
    case (ins[31:29])
      3'd0: begin en = 1'b0; redir = 1'b1; end
      3'd1: begin en = 1'b0; redir = (a == b); end
      3'd2: v = a + b;
      3'd3: v = a - b;
      3'd4: v = a << b[4:0];
      3'd5: v = a >> b[4:0];
      3'd6: begin d = ins[23:19]; v = a + imm; end
      default: begin d = ins[23:19]; v = a - imm; end
    endcase
    if (d == 5'd0) en = 1'b0;
    check("wb_en", {31'd0, wen}, {31'd0, en});
    if (en) begin
      check("wb_addr", {27'd0, wa}, {27'd0, d});
      check("wb_data", wd, v);
      ref_regs[d] = v;
    end
    if (redir) begin
      exp_pj = 1'b1;
      exp_ja = ins[4:0];
      ref_pc = ins[4:0];
    end else begin
      ref_pc = ref_pc + 5'd1;
    end
    exp_rc++;
  endtask

  // One clock: sample at negedge+1, then act as the fetch stage just after the posedge
  task automatic cycle();
    logic        ctl, pj, wen, st;
    logic [4:0]  ja, wa;
    logic [31:0] wd;
    logic [15:0] rc;
    @(negedge clk);
    #1;
    ctl = bus.control; pj = bus.pc_jump; ja = bus.jump_addr;
    wen = bus.wb_en;   wa = bus.wb_addr; wd = bus.wb_data;
    rc  = bus.retired_count; st = bus.stall;
    if (rst_n) begin
      if (rc != prev_rc) begin
        retire_model(prev_wen, prev_waddr, prev_wdata);
        check("retired_count", {16'd0, rc}, exp_rc);
      end else if (prev_wen) begin
        check("spurious_wen", {31'd0, prev_wen}, 32'd0);
      end
      if (st) begin
        check("stall_control", {31'd0, ctl}, 32'd0);
        check("stall_wen", {31'd0, wen}, 32'd0);
      end else begin
        if (first_ctl) begin
          check("first_control", {31'd0, ctl}, 32'd1);
          first_ctl = 1'b0;
        end
        gap++;
        if (ctl) begin
          check("pc_jump", {31'd0, pj}, {31'd0, exp_pj});
          if (exp_pj) check("jump_addr", {27'd0, ja}, {27'd0, exp_ja});
          if (have_ctl) check("fetch_gap", gap, last_pj ? 32'd1 : 32'd4);
          have_ctl = 1'b1;
          last_pj  = pj;
          gap      = 0;
          exp_pj   = 1'b0;
        end
      end
      prev_wen = wen; prev_waddr = wa; prev_wdata = wd; prev_rc = rc;
      if (abort_on_wen && wen) begin
        rst_n = 1'b0;
        abort_on_wen = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pc = 5'd0;
    end else if (ctl) begin
      bus.instruction = mem[pc];
      pc = pj ? ja : pc + 5'd1;
    end
  endtask

  task automatic run(input int n, input int stall_pct, input int budget);
    int target, cnt;
    target = exp_rc + n;
    cnt    = 0;
    while (exp_rc < target && cnt < budget) begin
      bus.stall = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
      cycle();
      cnt++;
    end
    bus.stall = 1'b0;
    if (exp_rc < target) check("run_timeout", exp_rc, target);
  endtask

  task automatic freeze();
    bus.stall = 1'b1;
  endtask

  task automatic unfreeze();
    @(posedge clk);
    #1;
    bus.stall = 1'b0;
  endtask

  task automatic dbg_check(input string tag, input int idx, input logic [31:0] exp);
    bus.dbg_addr = idx[4:0];
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_control", {31'd0, bus.control}, 32'd0);
    check("rst_pc_jump", {31'd0, bus.pc_jump}, 32'd0);
    check("rst_jump_addr", {27'd0, bus.jump_addr}, 32'd0);
    check("rst_wb_en", {31'd0, bus.wb_en}, 32'd0);
    check("rst_wb_addr", {27'd0, bus.wb_addr}, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_retired", {16'd0, bus.retired_count}, 32'd0);
    for (int i = 0; i < 32; i++) dbg_check("rst_dbg", i, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    ref_pc = 5'd0; pc = 5'd0; exp_rc = 0; exp_pj = 1'b0; exp_ja = 5'd0;
    prev_wen = 1'b0; prev_waddr = 5'd0; prev_wdata = 32'd0; prev_rc = 16'd0;
    gap = 0; have_ctl = 1'b0; last_pj = 1'b0; first_ctl = 1'b1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 32; i++) mem[i] = i_ins(3'd6, 5'd0, 5'd0, 16'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; bus.stall = 1'b0; bus.instruction = 32'd0; bus.dbg_addr = 5'd0;
    pc = 5'd0; abort_on_wen = 1'b0;

    fill_nop();
    mem[0] = i_ins(3'd6, 5'd10, 5'd0, 16'd10);
    mem[1] = i_ins(3'd6, 5'd15, 5'd0, 16'd15);
    mem[2] = r_ins(3'd2, 5'd25, 5'd10, 5'd15);
    mem[3] = i_ins(3'd7, 5'd20, 5'd25, 16'd5);
    do_reset();
    run(4, 0, 100);
    check("chain_count", {16'd0, bus.retired_count}, 32'd4);
    freeze();
    dbg_check("chain_r25", 25, 32'd25);
    dbg_check("chain_r20", 20, 32'd20);
    unfreeze();

    fill_nop();
    mem[0]  = i_ins(3'd6, 5'd31, 5'd0, 16'd7);
    mem[1]  = j_ins(3'd0, 5'd0, 5'd0, 5'd12);
    mem[2]  = r_ins(3'd4, 5'd30, 5'd31, 5'd0);
    mem[12] = i_ins(3'd6, 5'd7, 5'd0, 16'd77);
    do_reset();
    run(3, 0, 100);
    freeze();
    dbg_check("flush_r30", 30, 32'd0);
    dbg_check("jump_r7", 7, 32'd77);
    unfreeze();

    fill_nop();
    mem[0]  = i_ins(3'd6, 5'd4, 5'd0, 16'd4);
    mem[1]  = j_ins(3'd1, 5'd4, 5'd5, 5'd20);
    mem[2]  = i_ins(3'd6, 5'd5, 5'd0, 16'd4);
    mem[3]  = j_ins(3'd1, 5'd4, 5'd5, 5'd20);
    mem[4]  = i_ins(3'd6, 5'd9, 5'd0, 16'd1);
    mem[20] = i_ins(3'd6, 5'd8, 5'd0, 16'd8);
    do_reset();
    run(5, 0, 100);
    freeze();
    dbg_check("beq_stale_r9", 9, 32'd0);
    dbg_check("beq_target_r8", 8, 32'd8);
    unfreeze();

    fill_nop();
    mem[0] = i_ins(3'd6, 5'd0, 5'd0, 16'd5);
    mem[1] = i_ins(3'd7, 5'd1, 5'd0, 16'd1);
    mem[2] = i_ins(3'd6, 5'd2, 5'd0, 16'd33);
    mem[3] = i_ins(3'd6, 5'd3, 5'd0, 16'd3);
    mem[4] = r_ins(3'd4, 5'd6, 5'd3, 5'd2);
    mem[5] = r_ins(3'd5, 5'd11, 5'd1, 5'd2);
    do_reset();
    run(6, 0, 100);
    freeze();
    dbg_check("r0_zero", 0, 32'd0);
    dbg_check("subi_wrap_r1", 1, 32'hFFFF_FFFF);
    dbg_check("shl33_r6", 6, 32'd6);
    dbg_check("shr33_r11", 11, 32'h7FFF_FFFF);
    unfreeze();

    fill_nop();
    mem[0] = i_ins(3'd6, 5'd12, 5'd0, 16'h1234);
    mem[1] = r_ins(3'd2, 5'd14, 5'd12, 5'd12);
    do_reset();
    cycle();
    cycle();
    bus.stall = 1'b1;
    repeat (5) cycle();
    bus.stall = 1'b0;
    run(2, 0, 50);
    freeze();
    dbg_check("stall_r12", 12, 32'h1234);
    dbg_check("stall_r14", 14, 32'h2468);
    unfreeze();

    fill_nop();
    mem[0] = i_ins(3'd6, 5'd13, 5'd0, 16'd99);
    do_reset();
    abort_on_wen = 1'b1;
    for (int i = 0; i < 10 && rst_n; i++) cycle();
    if (rst_n) check("abort_reached_wb", {31'd0, rst_n}, 32'd0);
    abort_on_wen = 1'b0;
    do_reset();
    check("abort_count", {16'd0, bus.retired_count}, 32'd0);

    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      do_reset();
      run(60, 25, 3000);
      freeze();
      for (int i = 0; i < 32; i++) dbg_check("rand_reg", i, ref_regs[i]);
      unfreeze();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
